// File: rtl/dmem_pkg.sv
// Shared types and helpers for the wait-stated data memory responder.
// Optional feature macro: DMEM_BYTE_STROBE_EN (per-byte store strobes).
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam int WORD_BYTES = 4;

  // A request is rejected when it is not word aligned or its word index lies past the array.
  function automatic logic is_bad_addr(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || (32'(addr[31:2]) >= depth);
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response handshake bundle between a data-port requester and the memory responder.
// Carries req_wstrb only when DMEM_BYTE_STROBE_EN is defined.
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
`ifdef DMEM_BYTE_STROBE_EN
  logic [3:0]  req_wstrb;
`endif
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
`ifdef DMEM_BYTE_STROBE_EN
    output req_wstrb,
`endif
    output req_valid, output req_we, output req_addr, output req_wdata,
    output resp_ready,
    input  req_ready, input resp_valid, input resp_rdata, input resp_err
  );

  modport slave (
`ifdef DMEM_BYTE_STROBE_EN
    input  req_wstrb,
`endif
    input  req_valid, input req_we, input req_addr, input req_wdata,
    input  resp_ready,
    output req_ready, output resp_valid, output resp_rdata, output resp_err
  );
endinterface

// File: rtl/dmem_array.sv
// Word RAM with synchronous write and combinational read; no reset so contents survive reset.
// With DMEM_BYTE_STROBE_EN defined, writes are masked per byte lane.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
`ifdef DMEM_BYTE_STROBE_EN
  input  logic [3:0]    wstrb,
`endif
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

`ifdef DMEM_BYTE_STROBE_EN
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (wstrb[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end
`endif

  assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Wait-stated data memory responder: one request at a time, LATENCY wait cycles, then access and respond.
// Optional feature macro: DMEM_BYTE_STROBE_EN adds byte-lane store strobes.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input logic   clk,
  input logic   reset,
  dmem_if.slave bus
);

  localparam int         AW  = $clog2(DEPTH);
  localparam logic [3:0] LAT = 4'(LATENCY);

  dmem_state_t state;
  logic [3:0]  cnt;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
`ifdef DMEM_BYTE_STROBE_EN
  logic [3:0]  lat_wstrb;
`endif
  logic        req_ready_q;
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic        resp_err_q;

  logic          bad;
  logic          access;
  logic          mem_we;
  logic [AW-1:0] idx;
  logic [31:0]   mem_rdata;

  assign bad    = is_bad_addr(lat_addr, DEPTH);
  assign access = (state == WAIT) && (cnt == 4'd0);
  // Gated by state so an async reset during WAIT can never let a store slip into the array.
  assign mem_we = access && lat_we && !bad;
  assign idx    = lat_addr[AW+1:2];

  dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk   (clk),
    .we    (mem_we),
`ifdef DMEM_BYTE_STROBE_EN
    .wstrb (lat_wstrb),
`endif
    .idx   (idx),
    .wdata (lat_wdata),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      lat_we       <= 1'b0;
      lat_addr     <= 32'd0;
      lat_wdata    <= 32'd0;
`ifdef DMEM_BYTE_STROBE_EN
      lat_wstrb    <= 4'd0;
`endif
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid && req_ready_q) begin
            lat_we      <= bus.req_we;
            lat_addr    <= bus.req_addr;
            lat_wdata   <= bus.req_wdata;
`ifdef DMEM_BYTE_STROBE_EN
            lat_wstrb   <= bus.req_wstrb;
`endif
            cnt         <= LAT;
            req_ready_q <= 1'b0;
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            resp_valid_q <= 1'b1;
            resp_err_q   <= bad;
            resp_rdata_q <= (bad || lat_we) ? 32'd0 : mem_rdata;
            state        <= RESP;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
            req_ready_q  <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, hand-written corner sequences and a randomized
// run against an array-based memory model. Byte-strobe checks run when DMEM_BYTE_STROBE_EN is defined.
module tb_dmem_responder;
  localparam int DEPTH   = 64;
  localparam int LATENCY = 2;
  localparam int BOUND   = 50;

  logic clk;
  logic reset;
  dmem_if intf();

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (intf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] ref_mem   [DEPTH];
  logic        ref_known [DEPTH];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory model: plain word array plus a per-word "contents known" flag.
  task automatic modelAccess(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] wstrb, output logic [31:0] rdata,
                             output logic err, output logic known);
    int unsigned w;
    logic [3:0] lanes;
`ifdef DMEM_BYTE_STROBE_EN
    lanes = wstrb;
`else
    lanes = 4'hF;
`endif
    err   = (addr % 4 != 0) || (addr >= DEPTH * 4);
    rdata = 32'd0;
    known = 1'b1;
    if (!err) begin
      w = addr / 4;
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (lanes[b]) ref_mem[w][8*b +: 8] = wdata[8*b +: 8];
        if (lanes == 4'hF) ref_known[w] = 1'b1;
      end else begin
        rdata = ref_mem[w];
        known = ref_known[w];
      end
    end
  endtask

  task automatic sendRequest(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] wstrb);
    int guard = 0;
    @(negedge clk);
    while (!intf.req_ready && guard < BOUND) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("req_ready_before_accept", {31'd0, intf.req_ready}, 32'd1);
    intf.req_valid = 1'b1;
    intf.req_we    = we;
    intf.req_addr  = addr;
    intf.req_wdata = wdata;
`ifdef DMEM_BYTE_STROBE_EN
    intf.req_wstrb = wstrb;
`endif
    @(posedge clk);
    #1;
    intf.req_valid = 1'b0;
    intf.req_we    = 1'($urandom);
    intf.req_addr  = $urandom;
    intf.req_wdata = $urandom;
`ifdef DMEM_BYTE_STROBE_EN
    intf.req_wstrb = 4'($urandom);
`endif
  endtask

  task automatic waitResponse(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!intf.resp_valid && lat < BOUND);
  endtask

  task automatic finishResponse(input string name);
    intf.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    intf.resp_ready = 1'b0;
    checkOutput({name, "_idle_resp_valid"}, {31'd0, intf.resp_valid}, 32'd0);
    checkOutput({name, "_idle_req_ready"},  {31'd0, intf.req_ready},  32'd1);
    checkOutput({name, "_idle_rdata"},      intf.resp_rdata,          32'd0);
    checkOutput({name, "_idle_err"},        {31'd0, intf.resp_err},   32'd0);
  endtask

  task automatic applyStimulus(input string name, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] wstrb,
                               input logic check_data, input logic [31:0] exp_rdata,
                               input logic exp_err);
    int lat;
    sendRequest(we, addr, wdata, wstrb);
    waitResponse(lat);
    checkOutput({name, "_latency"},    32'(lat), 32'(LATENCY + 1));
    checkOutput({name, "_resp_valid"}, {31'd0, intf.resp_valid}, 32'd1);
    checkOutput({name, "_req_ready"},  {31'd0, intf.req_ready},  32'd0);
    checkOutput({name, "_err"},        {31'd0, intf.resp_err},   {31'd0, exp_err});
    if (check_data) checkOutput({name, "_rdata"}, intf.resp_rdata, exp_rdata);
    finishResponse(name);
  endtask

  initial begin
    logic [31:0] m_rdata;
    logic        m_err;
    logic        m_known;
    int          lat;

    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i]   = 32'd0;
      ref_known[i] = 1'b0;
    end
    intf.req_valid  = 1'b0;
    intf.req_we     = 1'b0;
    intf.req_addr   = 32'd0;
    intf.req_wdata  = 32'd0;
`ifdef DMEM_BYTE_STROBE_EN
    intf.req_wstrb  = 4'hF;
`endif
    intf.resp_ready = 1'b0;

    vecs.push_back('{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0010, 32'h0000_0000, 4'hF, 32'hDEAD_BEEF, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_0020, 32'h0123_4567, 4'hF, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b1, 32'h0000_0012, 32'h7777_7777, 4'hF, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b0, 32'h0000_0010, 32'h0000_0000, 4'hF, 32'hDEAD_BEEF, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0100, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b1, 32'h0000_0100, 32'h1111_1111, 4'hF, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b1, 32'h0000_00FC, 32'h55AA_55AA, 4'hF, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_00FC, 32'h0000_0000, 4'hF, 32'h55AA_55AA, 1'b0});
    vecs.push_back('{1'b0, 32'h0000_0000, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b0, 32'h8000_0010, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b0, 32'h0000_0023, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b0, 32'h0000_0020, 32'h0000_0000, 4'hF, 32'h0123_4567, 1'b0});
    // Entry 10 deliberately hits word 0 unaligned-free but out of range is not; fix expectation below.
    vecs[9].exp_err = 1'b0;
    vecs[9].addr    = 32'h0000_0002;
    vecs[9].exp_err = 1'b1;

    // Reset held for three cycles.
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_req_ready",  {31'd0, intf.req_ready},  32'd1);
    checkOutput("reset_resp_valid", {31'd0, intf.resp_valid}, 32'd0);
    checkOutput("reset_rdata",      intf.resp_rdata,          32'd0);
    checkOutput("reset_err",        {31'd0, intf.resp_err},   32'd0);
    @(negedge clk);
    reset = 1'b1;

    $display("[TB] directed vector table");
    for (int i = 0; i < vecs.size(); i++) begin
      modelAccess(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, m_rdata, m_err, m_known);
      applyStimulus($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb,
                    1'b1, vecs[i].exp_rdata, vecs[i].exp_err);
    end

    $display("[TB] backpressure with ignored request pulses");
    sendRequest(1'b0, 32'h10, 32'd0, 4'hF);
    waitResponse(lat);
    checkOutput("bp_latency", 32'(lat), 32'(LATENCY + 1));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      intf.req_valid = 1'b1;
      intf.req_we    = 1'b1;
      intf.req_addr  = 32'h10;
      intf.req_wdata = 32'h0BAD_0BAD;
      @(posedge clk);
      #1;
      intf.req_valid = 1'b0;
      checkOutput("bp_resp_valid", {31'd0, intf.resp_valid}, 32'd1);
      checkOutput("bp_rdata",      intf.resp_rdata,          32'hDEAD_BEEF);
      checkOutput("bp_req_ready",  {31'd0, intf.req_ready},  32'd0);
      checkOutput("bp_err",        {31'd0, intf.resp_err},   32'd0);
    end
    finishResponse("bp");
    applyStimulus("bp_reload", 1'b0, 32'h10, 32'd0, 4'hF, 1'b1, 32'hDEAD_BEEF, 1'b0);

`ifdef DMEM_BYTE_STROBE_EN
    $display("[TB] byte strobes");
    modelAccess(1'b1, 32'h10, 32'h1122_3344, 4'b0101, m_rdata, m_err, m_known);
    applyStimulus("strb_store", 1'b1, 32'h10, 32'h1122_3344, 4'b0101, 1'b1, 32'd0, 1'b0);
    applyStimulus("strb_load",  1'b0, 32'h10, 32'd0, 4'hF, 1'b1, 32'hDE22_BE44, 1'b0);
    modelAccess(1'b1, 32'h10, 32'hFFFF_FFFF, 4'b0000, m_rdata, m_err, m_known);
    applyStimulus("strb_zero",  1'b1, 32'h10, 32'hFFFF_FFFF, 4'b0000, 1'b1, 32'd0, 1'b0);
    applyStimulus("strb_keep",  1'b0, 32'h10, 32'd0, 4'hF, 1'b1, 32'hDE22_BE44, 1'b0);
`endif

    $display("[TB] reset during WAIT abandons the store");
    sendRequest(1'b1, 32'h20, 32'hCAFE_F00D, 4'hF);
    reset = 1'b0;
    #1;
    checkOutput("rst_wait_req_ready",  {31'd0, intf.req_ready},  32'd1);
    checkOutput("rst_wait_resp_valid", {31'd0, intf.resp_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus("rst_wait_load", 1'b0, 32'h20, 32'd0, 4'hF, 1'b1, 32'h0123_4567, 1'b0);

    $display("[TB] reset during RESP keeps the store");
    sendRequest(1'b1, 32'h20, 32'hCAFE_F00D, 4'hF);
    waitResponse(lat);
    checkOutput("rst_resp_latency", 32'(lat), 32'(LATENCY + 1));
    reset = 1'b0;
    #1;
    checkOutput("rst_resp_resp_valid", {31'd0, intf.resp_valid}, 32'd0);
    checkOutput("rst_resp_rdata",      intf.resp_rdata,          32'd0);
    checkOutput("rst_resp_req_ready",  {31'd0, intf.req_ready},  32'd1);
    @(negedge clk);
    reset = 1'b1;
    modelAccess(1'b1, 32'h20, 32'hCAFE_F00D, 4'hF, m_rdata, m_err, m_known);
    applyStimulus("rst_resp_load", 1'b0, 32'h20, 32'd0, 4'hF, 1'b1, 32'hCAFE_F00D, 1'b0);

    $display("[TB] randomized traffic against the model");
    for (int i = 0; i < 80; i++) begin
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      int          kind;
      kind  = $urandom_range(0, 9);
      we    = 1'($urandom);
      wdata = $urandom;
      wstrb = 4'($urandom);
      addr  = 32'($urandom_range(0, DEPTH - 1)) * 4;
      if (kind == 0) addr = addr + 32'($urandom_range(1, 3));
      else if (kind == 1) addr = 32'(DEPTH * 4) + 32'($urandom_range(0, 1000)) * 4;
      else if (kind == 2) addr = {1'b1, 31'($urandom)} & 32'hFFFF_FFFC;
      modelAccess(we, addr, wdata, wstrb, m_rdata, m_err, m_known);
      applyStimulus($sformatf("rnd%0d", i), we, addr, wdata, wstrb, m_known, m_rdata, m_err);
    end

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
